// File: rtl/bfloat16_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfloat16_rf_pkg
// Description : Shared widths and FSM encoding for the bfloat16 2R1W file.
// Revision    : 1.0 - initial release
// ============================================================================
package bfloat16_rf_pkg;

    localparam int c_default_addr_width = 5;
    localparam int c_default_data_width = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/bfloat16_rf_2r1w_if.sv
`default_nettype none
// ============================================================================
// Module      : bfloat16_rf_2r1w_if
// Description : Write, dual read and clear signalling of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface bfloat16_rf_2r1w_if #(
    parameter int ADDR_WIDTH = bfloat16_rf_pkg::c_default_addr_width,
    parameter int DATA_WIDTH = bfloat16_rf_pkg::c_default_data_width
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re0;
    logic                  re1;
    logic [ADDR_WIDTH-1:0] raddr0;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  clr;
    logic                  busy;
    logic                  clr_done;

    modport master (
        output we, waddr, wdata, re0, re1, raddr0, raddr1, clr,
        input  rdata0, rdata1, rvalid0, rvalid1, busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, re0, re1, raddr0, raddr1, clr,
        output rdata0, rdata1, rvalid0, rvalid1, busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/bfloat16_rf_rport.sv
`default_nettype none
// ============================================================================
// Module      : bfloat16_rf_rport
// Description : One registered read port with optional write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat16_rf_rport
    import bfloat16_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int BYPASS     = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_x,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    input  wire logic [DATA_WIDTH-1:0] i_mem_data,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata,
    output logic                       o_rvalid
);
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    // Forwarding covers both user writes and the zero written by a clear.
    assign w_hit = (BYPASS != 0) && i_wr_en && (i_waddr == i_raddr);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) begin
                r_rdata <= w_hit ? i_wdata : i_mem_data;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
endmodule
`default_nettype wire

// File: rtl/bfloat16_rf_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : bfloat16_rf_2r1w
// Description : bfloat16 register file, 2 read / 1 write, with bulk clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat16_rf_2r1w
    import bfloat16_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int BYPASS     = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_x,
    bfloat16_rf_2r1w_if.slave  bus
);
    localparam int                    c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(c_DEPTH - 1);

    rf_state_e             r_state;
    rf_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_clr_done;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // The single storage write port is owned by the user in IDLE and by the
    // clear sweep in CLEAR, so user writes during a clear simply vanish.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.waddr;
        w_mem_wdata = bus.wdata;
        case (r_state)
            IDLE: begin
                w_mem_we = bus.we;
                if (bus.clr) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cnt;
                w_mem_wdata = '0;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= (r_state == CLEAR) && (r_cnt == c_LAST);
            if (r_state == CLEAR && r_cnt != c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign bus.busy     = (r_state == CLEAR);
    assign bus.clr_done = r_clr_done;

    bfloat16_rf_rport #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS     (BYPASS)
    ) u_rport0 (
        .clk        (clk),
        .rst_x      (rst_x),
        .i_re       (bus.re0),
        .i_raddr    (bus.raddr0),
        .i_mem_data (r_mem[bus.raddr0]),
        .i_wr_en    (w_mem_we),
        .i_waddr    (w_mem_addr),
        .i_wdata    (w_mem_wdata),
        .o_rdata    (bus.rdata0),
        .o_rvalid   (bus.rvalid0)
    );

    bfloat16_rf_rport #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS     (BYPASS)
    ) u_rport1 (
        .clk        (clk),
        .rst_x      (rst_x),
        .i_re       (bus.re1),
        .i_raddr    (bus.raddr1),
        .i_mem_data (r_mem[bus.raddr1]),
        .i_wr_en    (w_mem_we),
        .i_waddr    (w_mem_addr),
        .i_wdata    (w_mem_wdata),
        .o_rdata    (bus.rdata1),
        .o_rvalid   (bus.rvalid1)
    );
endmodule
`default_nettype wire

// File: tb/tb_bfloat16_rf_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfloat16_rf_2r1w
// Description : Bench for bfloat16_rf_2r1w; forwarding and non-forwarding
//               instances share stimulus and are checked against one model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfloat16_rf_2r1w;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_x = 1'b0;
    always #5 clk = ~clk;

    bfloat16_rf_2r1w_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    bfloat16_rf_2r1w_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus1.we     = bus0.we;
    assign bus1.waddr  = bus0.waddr;
    assign bus1.wdata  = bus0.wdata;
    assign bus1.re0    = bus0.re0;
    assign bus1.re1    = bus0.re1;
    assign bus1.raddr0 = bus0.raddr0;
    assign bus1.raddr1 = bus0.raddr1;
    assign bus1.clr    = bus0.clr;

    bfloat16_rf_2r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1)) dut_bp (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus0)
    );

    bfloat16_rf_2r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index [b][p], b=0 forwarding instance, b=1 non-forwarding.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_clearing = 1'b0;
    int            m_cnt      = 0;
    logic [DW-1:0] exp_rd [2][2];
    bit            exp_kn [2][2];
    bit            exp_rv [2][2];
    bit            exp_done = 1'b0;
    bit            exp_busy = 1'b0;
    bit            mw_en;
    int            mw_a;
    logic [DW-1:0] mw_d;
    bit            re_in [2];
    int            ra_in [2];

    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            m_clearing = 1'b0;
            m_cnt      = 0;
            exp_done   = 1'b0;
            exp_busy   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    exp_rd[b][p] = '0;
                    exp_kn[b][p] = 1'b1;
                    exp_rv[b][p] = 1'b0;
                end
            end
        end else begin
            re_in[0] = bus0.re0;
            re_in[1] = bus0.re1;
            ra_in[0] = int'(bus0.raddr0);
            ra_in[1] = int'(bus0.raddr1);
            // Entry changing this edge: the next clear slot, else a user write.
            mw_en = m_clearing || bus0.we;
            mw_a  = m_clearing ? m_cnt : int'(bus0.waddr);
            mw_d  = m_clearing ? '0 : bus0.wdata;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    exp_rv[b][p] = re_in[p];
                    if (re_in[p]) begin
                        if (b == 0 && mw_en && ra_in[p] == mw_a) begin
                            exp_rd[b][p] = mw_d;
                            exp_kn[b][p] = 1'b1;
                        end else begin
                            exp_rd[b][p] = m_mem[ra_in[p]];
                            exp_kn[b][p] = m_known[ra_in[p]];
                        end
                    end
                end
            end
            exp_done = m_clearing && (m_cnt == DEPTH - 1);
            if (mw_en) begin
                m_mem[mw_a]   = mw_d;
                m_known[mw_a] = 1'b1;
            end
            if (m_clearing) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_clearing = 1'b0;
                    m_cnt      = 0;
                end
            end else if (bus0.clr) begin
                m_clearing = 1'b1;
                m_cnt      = 0;
            end
            exp_busy = m_clearing;
        end
    end

    logic [DW-1:0] act_rd [2][2];
    logic          act_rv [2][2];
    assign act_rd[0][0] = bus0.rdata0;
    assign act_rd[0][1] = bus0.rdata1;
    assign act_rd[1][0] = bus1.rdata0;
    assign act_rd[1][1] = bus1.rdata1;
    assign act_rv[0][0] = bus0.rvalid0;
    assign act_rv[0][1] = bus0.rvalid1;
    assign act_rv[1][0] = bus1.rvalid0;
    assign act_rv[1][1] = bus1.rvalid1;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("model_rvalid[%0d][%0d]", b, p), act_rv[b][p], exp_rv[b][p]);
                    if (exp_kn[b][p]) begin
                        check($sformatf("model_rdata[%0d][%0d]", b, p), act_rd[b][p], exp_rd[b][p]);
                    end
                end
            end
            check("model_busy_bp", bus0.busy, exp_busy);
            check("model_busy_nb", bus1.busy, exp_busy);
            check("model_done_bp", bus0.clr_done, exp_done);
            check("model_done_nb", bus1.clr_done, exp_done);
        end
    end

    task automatic idle_in();
        bus0.we     = 1'b0;
        bus0.waddr  = '0;
        bus0.wdata  = '0;
        bus0.re0    = 1'b0;
        bus0.re1    = 1'b0;
        bus0.raddr0 = '0;
        bus0.raddr1 = '0;
        bus0.clr    = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bus0.we    = 1'b1;
        bus0.waddr = AW'(a);
        bus0.wdata = d;
        @(negedge clk);
        bus0.we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int nbusy;
    int ndone;

    initial begin
        idle_in();
        rst_x = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdata0", bus0.rdata0, 16'h0000);
        check("reset_rvalid1", bus0.rvalid1, 1'b0);
        check("reset_busy", bus0.busy, 1'b0);
        check("reset_clr_done", bus0.clr_done, 1'b0);
        rst_x  = 1'b1;
        cmp_en = 1'b1;

        // Basic write then read with one cycle of latency.
        wr(3, 16'h3F80);
        bus0.re0 = 1'b1; bus0.raddr0 = AW'(3);
        @(negedge clk);
        check("basic_rdata0", bus0.rdata0, 16'h3F80);
        check("basic_rvalid0", bus0.rvalid0, 1'b1);
        bus0.re0 = 1'b0;

        // Same-edge write and read of addr 7.
        wr(7, 16'h1234);
        bus0.we = 1'b1; bus0.waddr = AW'(7); bus0.wdata = 16'h4000;
        bus0.re1 = 1'b1; bus0.raddr1 = AW'(7);
        @(negedge clk);
        check("fwd_rdata1_bp", bus0.rdata1, 16'h4000);
        check("fwd_rdata1_nb", bus1.rdata1, 16'h1234);
        idle_in();
        bus0.re1 = 1'b1; bus0.raddr1 = AW'(7);
        @(negedge clk);
        check("after_fwd_rdata1_nb", bus1.rdata1, 16'h4000);
        idle_in();

        // Concurrent reads of addr 0 and 31 with toggling enables.
        wr(0, 16'h1111);
        wr(31, 16'h2222);
        for (int i = 0; i < 12; i++) begin
            bus0.re0    = (i % 3) != 0;
            bus0.re1    = (i % 2) == 0;
            bus0.raddr0 = (i % 2) != 0 ? AW'(31) : AW'(0);
            bus0.raddr1 = (i % 4) < 2 ? AW'(31) : AW'(0);
            @(negedge clk);
        end
        bus0.re0 = 1'b1; bus0.raddr0 = AW'(31);
        bus0.re1 = 1'b0;
        @(negedge clk);
        bus0.re0 = 1'b0; bus0.raddr0 = AW'(0);
        @(negedge clk);
        check("hold_rdata0", bus0.rdata0, 16'h2222);
        check("hold_rvalid0", bus0.rvalid0, 1'b0);

        // Fill, then clear with a same-edge write, a repeated clr and a dropped write.
        for (int i = 0; i < DEPTH; i++) wr(i, 16'h3F00 + 16'(i));
        bus0.clr = 1'b1;
        bus0.we = 1'b1; bus0.waddr = AW'(9); bus0.wdata = 16'hABCD;
        @(negedge clk);
        bus0.clr = 1'b0; bus0.we = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.busy) nbusy++;
            if (bus0.clr_done) ndone++;
            if (i == 4) begin
                check("clear_hit_bp", bus0.rdata0, 16'h0000);
                check("clear_hit_nb", bus1.rdata0, 16'h3F03);
            end
            bus0.re0    = (i == 3);
            bus0.raddr0 = AW'(3);
            bus0.clr    = (i == 5);
            bus0.we     = (i == 10);
            bus0.waddr  = AW'(5);
            bus0.wdata  = 16'hFFFF;
            @(negedge clk);
        end
        idle_in();
        check("clear_busy_cycles", nbusy, 32);
        check("clear_done_pulses", ndone, 1);
        for (int a = 0; a < DEPTH; a++) begin
            bus0.re0 = 1'b1; bus0.raddr0 = AW'(a);
            bus0.re1 = 1'b1; bus0.raddr1 = AW'(DEPTH - 1 - a);
            @(negedge clk);
            check($sformatf("cleared_p0_addr%0d", a), bus0.rdata0, 16'h0000);
            check($sformatf("cleared_p1_addr%0d", DEPTH - 1 - a), bus1.rdata1, 16'h0000);
        end
        idle_in();

        // Reset in the middle of a clear.
        bus0.clr = 1'b1;
        @(negedge clk);
        bus0.clr = 1'b0;
        bus0.re0 = 1'b1; bus0.raddr0 = AW'(1);
        repeat (10) @(negedge clk);
        #2 rst_x = 1'b0;
        #1;
        check("abort_busy", bus0.busy, 1'b0);
        check("abort_rvalid0", bus0.rvalid0, 1'b0);
        check("abort_clr_done", bus0.clr_done, 1'b0);
        check("abort_rdata0", bus0.rdata0, 16'h0000);
        @(negedge clk);
        rst_x = 1'b1;
        idle_in();
        @(negedge clk);
        check("post_abort_busy", bus0.busy, 1'b0);
        wr(4, 16'h4242);
        bus0.re0 = 1'b1; bus0.raddr0 = AW'(4);
        @(negedge clk);
        check("post_abort_rdata0", bus0.rdata0, 16'h4242);
        idle_in();
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bfloat16_rf_2r1w.md
BFLOAT16_RF_2R1W -- requirements
Module: bfloat16_rf_2r1w

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width (one bfloat16).
REQ-003 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (0 = off, 1 = on).
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_x  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports re0, re1  input  1  read enables for port 0 and port 1.
REQ-010 SHALL have ports raddr0, raddr1  input  ADDR_WIDTH  read addresses.
REQ-011 SHALL have ports rdata0, rdata1  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have ports rvalid0, rvalid1  output  1  read data valid.
REQ-013 SHALL have port clr  input  1  clear-all request.
REQ-014 SHALL have port busy  output  1  clear in progress.
REQ-015 SHALL have port clr_done  output  1  one-cycle pulse when the clear completes.

Function
REQ-016 Reads SHALL have 1-cycle latency: re sampled at edge k -> rdata and rvalid=1 valid after edge k.
REQ-017 A port with re=0 at an edge SHALL hold rdata and drive rvalid=0.
REQ-018 The ports SHALL be independent; both may read the same address in the same cycle.
REQ-019 A write SHALL occur at edge k when we=1 and state=IDLE; writes with we=1 in CLEAR SHALL be dropped.
REQ-020 With BYPASS=1, a read with raddr==waddr at the same edge as an accepted write SHALL return wdata; with BYPASS=0 it SHALL return the old contents.
REQ-021 The FSM SHALL have states IDLE and CLEAR; clr=1 at an edge in IDLE -> CLEAR, counter cnt=0.
REQ-022 In CLEAR, each edge SHALL write 0 to entry cnt and increment cnt; the edge writing DEPTH-1 SHALL return to IDLE.
REQ-023 busy SHALL equal (state==CLEAR); it is high for exactly DEPTH cycles per clear.
REQ-024 clr_done SHALL be registered and high for one cycle, following the edge that writes entry DEPTH-1.
REQ-025 clr=1 while in CLEAR SHALL be ignored (no restart).
REQ-026 clr=1 and we=1 at the same edge in IDLE: the write SHALL be performed, then the clear SHALL overwrite that entry.
REQ-027 Reads in CLEAR SHALL be serviced; a read hitting the entry being cleared at that edge SHALL return 0 when BYPASS=1.
REQ-028 cnt SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap past DEPTH-1 within one clear.

Reset
REQ-029 rst_x=0 SHALL immediately force rdata0=rdata1=0, rvalid0=rvalid1=0, busy=0, clr_done=0, state=IDLE, cnt=0.
REQ-030 The storage array SHALL NOT be reset; its contents after reset are undefined until written or cleared.
REQ-031 A reset during CLEAR SHALL abort the clear with no clr_done; partially cleared contents are undefined.

Structure
REQ-032 The shared package bfloat16_rf_pkg SHALL hold the state encoding (IDLE=0, CLEAR=1) and the default width constants.
REQ-033 The read port (register, valid flag, bypass mux) SHALL be a sub-module, bfloat16_rf_rport, instantiated twice.
REQ-034 The FSM, clear counter and write arbitration SHALL reside in the top module.

Verification
REQ-035 Write 0x3F80 to addr 3; next cycle re0=1, raddr0=3 -> rdata0=0x3F80 and rvalid0=1 one cycle later.
REQ-036 BYPASS=1: we=1, waddr=7, wdata=0x4000, re1=1, raddr1=7 on the same edge -> rdata1=0x4000; with BYPASS=0 -> the prior value.
REQ-037 Fill all 32 entries, pulse clr -> busy high 32 cycles, one-cycle clr_done pulse, all reads return 0x0000.
REQ-038 During CLEAR, we=1, waddr=5, wdata=0xFFFF -> write dropped; after clr_done, addr 5 reads 0x0000.
REQ-039 Assert rst_x=0 at CLEAR cycle 10 -> busy, rvalid and clr_done are 0 immediately; after release, state is IDLE and writes are accepted.
REQ-040 Both ports read addr 0 and addr 31 concurrently with re toggling -> rvalid tracks re delayed by one cycle, and rdata holds when re=0.
